// File: rtl/digit_sequencer.sv
// Plays a buffered sequence of 4-bit digit codes into the 7-segment decoder, with a blanking gap after each code.
// Latency: all outputs are registered, and playback starts one cycle after run is seen with a non-empty buffer.
// Backpressure: writes are accepted only in IDLE when the buffer is not full; a rejected write pulses wr_err one cycle later.
//
// Ports:
//   clk, rst_n        - system clock and asynchronous active-low reset
//   clear             - synchronous flush of buffer and playback; highest priority
//   wr_en, wr_data    - append one code (0..10) to the message buffer
//   run, loop         - level controls: play while run is high; loop restarts at entry 0
//   code, blank       - code driven to the decoder and segment-blank qualifier
//   busy, done        - busy in SHOW/GAP; done pulses when a non-looping pass completes
//   wr_err            - one-cycle pulse for a rejected write
//   count             - number of valid buffer entries
module digit_sequencer #(
    parameter int DEPTH        = 8,
    parameter int DWELL_CYCLES = 1000,
    parameter int GAP_CYCLES   = 250
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [3:0]                 wr_data,
    input  logic                       run,
    input  logic                       loop,
    output logic [3:0]                 code,
    output logic                       blank,
    output logic                       busy,
    output logic                       done,
    output logic                       wr_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IW   = $clog2(DEPTH);
    localparam int CW   = IW + 1;
    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [3:0]    MAX_CODE = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Message buffer. Contents are don't-care after reset; only entries
    // below count are ever read.
    logic [3:0] mem [DEPTH];

    state_t        state,     state_nxt;
    logic [IW-1:0] index,     index_nxt;
    logic [TW-1:0] timer,     timer_nxt;
    logic [3:0]    code_nxt;
    logic          blank_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          wr_err_nxt;
    logic [CW-1:0] count_nxt;
    logic          wr_acc;

    logic          wr_ok;
    logic          last_entry;
    logic [IW-1:0] index_inc;

    // A write is legal only while idle, with room left, and carrying a
    // code the decoder knows.
    assign wr_ok      = (state == IDLE) && (count < FULL) && (wr_data <= MAX_CODE);
    assign index_inc  = index + 1'b1;
    assign last_entry = ({1'b0, index} == (count - 1'b1));

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            index  <= '0;
            timer  <= '0;
            code   <= 4'd0;
            blank  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_err <= 1'b0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            index  <= index_nxt;
            timer  <= timer_nxt;
            code   <= code_nxt;
            blank  <= blank_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            wr_err <= wr_err_nxt;
            count  <= count_nxt;
        end
    end

    // Buffer storage has no reset; the slot at the current count is the
    // append position.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[count[IW-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        index_nxt  = index;
        timer_nxt  = timer;
        code_nxt   = code;
        done_nxt   = 1'b0;
        wr_err_nxt = 1'b0;
        count_nxt  = count;
        wr_acc     = 1'b0;

        if (clear) begin
            // Flush wins over everything: any same-cycle write or run is
            // dropped silently, and the timer is zeroed so a later start
            // always gets a full dwell.
            state_nxt = IDLE;
            index_nxt = '0;
            timer_nxt = '0;
            count_nxt = '0;
        end else begin
            if (wr_en) begin
                if (wr_ok) begin
                    wr_acc    = 1'b1;
                    count_nxt = count + 1'b1;
                end else begin
                    wr_err_nxt = 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    // Uses the pre-write count, so a write into an empty
                    // buffer with run held starts playback one cycle later.
                    if (run && (count != '0)) begin
                        state_nxt = SHOW;
                        index_nxt = '0;
                        timer_nxt = DWELL_LD;
                        code_nxt  = mem[0];
                    end
                end

                SHOW: begin
                    if (!run) begin
                        state_nxt = IDLE;
                        index_nxt = '0;
                        timer_nxt = '0;
                    end else if (timer == T_ONE) begin
                        state_nxt = GAP;
                        timer_nxt = GAP_LD;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end

                GAP: begin
                    if (!run) begin
                        state_nxt = IDLE;
                        index_nxt = '0;
                        timer_nxt = '0;
                    end else if (timer == T_ONE) begin
                        // End of a code slot: advance, wrap, or finish.
                        // loop only matters at this instant.
                        if (!last_entry) begin
                            state_nxt = SHOW;
                            index_nxt = index_inc;
                            timer_nxt = DWELL_LD;
                            code_nxt  = mem[index_inc];
                        end else if (loop) begin
                            state_nxt = SHOW;
                            index_nxt = '0;
                            timer_nxt = DWELL_LD;
                            code_nxt  = mem[0];
                        end else begin
                            state_nxt = IDLE;
                            index_nxt = '0;
                            timer_nxt = '0;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                    index_nxt = '0;
                    timer_nxt = '0;
                end
            endcase
        end

        // Segments are lit only while a code is being shown.
        blank_nxt = (state_nxt != SHOW);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: doc/digit_sequencer.md
Name: digit_sequencer

Overview:
- Plays a stored sequence of digit codes, one at a time, into the 7-segment decoder.
- Holds up to DEPTH 4-bit codes (0-9 digits, 10 = decimal point) written by the host logic, then sequences them with a fixed on-time.
- Inserts a blanking gap after every code so that repeated digits ("11") read as separate symbols.
- Sits between the input/control logic and the decoder: drives its code input, and drives a blank qualifier used to gate the segment outputs.

Parameters:
DEPTH, 8, number of code entries in the message buffer (power of two, 2..16)
DWELL_CYCLES, 1000, clock cycles each code is shown (>=1)
GAP_CYCLES, 250, clock cycles of blanking after each code (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush: empties buffer, aborts playback
wr_en  input  1  append wr_data to buffer this cycle
wr_data  input  4  code to append, legal 0..10
run  input  1  level: play while high
loop  input  1  level: 1 = restart at entry 0 after last entry, 0 = stop
code  output  4  current code to decoder, always 0..10
blank  output  1  1 = segments must be dark
busy  output  1  1 while in SHOW or GAP
done  output  1  one-cycle pulse when a non-looping pass completes
wr_err  output  1  one-cycle pulse when a write is rejected
count  output  log2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, rst_n low): code=0, blank=1, busy=0, done=0, wr_err=0, count=0, state IDLE, index 0, timer 0. Buffer contents don't care.
- All outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, SHOW, GAP.
- IDLE -> SHOW when run=1 and count>0. Next cycle: index=0, code=buf[0], blank=0, busy=1, timer loaded.
- If run=1 and count=0, the FSM stays in IDLE and done is not pulsed.
- SHOW: code is held with blank=0 for exactly DWELL_CYCLES cycles, then the FSM enters GAP.
- GAP: blank=1 for exactly GAP_CYCLES cycles; code holds its last value. At the end of GAP:
  - index < count-1: index+1, back to SHOW.
  - index = count-1 and loop=1: index=0, back to SHOW.
  - index = count-1 and loop=0: go to IDLE, busy=0, done=1 for one cycle.
- loop is sampled only at the end of GAP.
- run low in SHOW or GAP: next cycle IDLE, blank=1, busy=0, no done pulse, index reset to 0. Buffer is kept.
- Writes are accepted only in IDLE with count<DEPTH and wr_data<=10. An accepted write stores the code at buf[count], and count increments next cycle.
- Rejected writes (busy, full, or wr_data>10) leave buffer and count unchanged, and wr_err pulses one cycle later.
- clear has the highest priority:
  - Next cycle: count=0, IDLE, blank=1, busy=0, index=0.
  - A same-cycle wr_en is dropped without wr_err; a same-cycle run is ignored.
  - done is not pulsed.
- wr_en and run high together in IDLE: the write is accepted first. Playback starts on that same cycle using the count value sampled before the write. If that count was 0, playback starts on the following cycle instead.
- code never leaves 0..10, so the decoder is never driven to an unlisted value.
- Timer width is ceil(log2(max(DWELL_CYCLES,GAP_CYCLES)))+1. It counts down to 1, and terminal count causes the state change.
- Abort at any cycle (run low, clear, or rst_n) leaves no residual timer state; the next start always begins a full DWELL.

Test Plan:
(Bench parameters: DEPTH=4, DWELL_CYCLES=4, GAP_CYCLES=2.)
- Reset mid-SHOW: pull rst_n low asynchronously -> blank=1, busy=0, count=0, code=0 immediately, without waiting for a clock edge.
- Write 3, 1, 1 then run=1, loop=0 -> code sequence 3×4 (blank 0), gap×2 (blank 1), 1×4, gap×2, 1×4, gap×2. Then done pulses exactly once, busy=0, count stays 3.
- Write 4 entries, then a 5th write with wr_data=7 -> wr_err pulse, count=4. Write wr_data=12 in an empty buffer -> wr_err, count=0.
- Load 5,10, loop=1, run=1 for 30 cycles -> pattern 5,gap,10,gap repeats with period 12 cycles and no done. Drop run mid-SHOW -> IDLE next cycle, blank=1, no done.
- In IDLE with count=2, assert clear, wr_en and run together -> count=0 next cycle, no wr_err, state stays IDLE. Write during busy -> wr_err, buffer unchanged.
- run=1 with count=0 -> stays IDLE, blank=1, no done. Write 9 with run held -> playback of 9 begins the following cycle.
